mem_arbiter: RTL

//  Shares the single multi-cycle memory (1-cycle write, 4-cycle pipelined read, 16-bit words)

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory between I-cache fills and D-cache fills/write-through stores.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache always wins a tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BLOCK_WORDS  = 8,
  parameter int READ_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [15:0]                  d_wdata,
  output logic                         i_grant,
  output logic                         d_grant,
  output logic                         fill_valid,
  output logic [15:0]                  fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         mem_enable,
  output logic                         mem_wr,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [15:0]                  mem_data_in,
  input  logic [15:0]                  mem_data_out,
  input  logic                         mem_data_valid
);
  localparam int WIDX = $clog2(BLOCK_WORDS);
  localparam int CW = WIDX + 1;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state, state_n;
  logic owner_d, pick_d, go, in_fill, in_write, issuing, last;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic [ADDR_WIDTH-1:0] addr, sel_addr;
  logic [15:0] wdata;
`ifdef ARB_RR_EN
  logic last_d;
  assign pick_d = d_req & (~i_req | ~last_d);
`else
  assign pick_d = d_req;
`endif
  assign go = i_req | d_req;
  assign sel_addr = pick_d ? d_addr : i_addr;
  assign in_fill = state == FILL;
  assign in_write = state == WRITE;
  assign issuing = in_fill && issue_cnt < CW'(BLOCK_WORDS);
  assign last = fill_valid && recv_cnt == CW'(BLOCK_WORDS - 1);
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = go ? ((pick_d & d_wr) ? WRITE : FILL) : IDLE;
    else if (in_fill)
      state_n = last ? IDLE : FILL;
    else
      state_n = IDLE;
  end
  always_comb begin
    mem_enable  = issuing | in_write;
    mem_wr      = in_write;
    mem_addr    = issuing ? addr + ADDR_WIDTH'({issue_cnt, 1'b0}) : in_write ? addr : '0;
    mem_data_in = in_write ? wdata : '0;
    fill_valid  = in_fill & mem_data_valid;
    fill_data   = fill_valid ? mem_data_out : '0;
    fill_word   = fill_valid ? recv_cnt[WIDX-1:0] : '0;
    i_grant     = in_fill & ~owner_d;
    d_grant     = (in_fill | in_write) & owner_d;
    i_done      = last & ~owner_d;
    d_done      = (last & owner_d) | in_write;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      owner_d   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && go) begin
        owner_d   <= pick_d;
        addr      <= (pick_d & d_wr) ? {sel_addr[ADDR_WIDTH-1:1], 1'b0}
                                     : {sel_addr[ADDR_WIDTH-1:WIDX+1], {(WIDX+1){1'b0}}};
        wdata     <= d_wdata;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
      if (issuing) issue_cnt <= issue_cnt + 1'b1;
      if (fill_valid) recv_cnt <= recv_cnt + 1'b1;
    end
  end
`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) last_d <= 1'b0;
    else if (i_done | d_done) last_d <= d_done;
  end
`endif
endmodule
